// File: rtl/mem_align_unit.sv
// mem_align_unit: load/store alignment engine between the MEM stage and the data-memory port.
// Define MISALIGN_SPLIT_EN to split bus-word-crossing accesses into two memory transactions.
module mem_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_wmask,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]       mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                idle_s, illegal_s, err_s;
  logic [2:0]          cur_f3_s;
  logic [ADDR_W-1:0]   cur_addr_s;
  logic [DATA_W-1:0]   cur_wdata_s;
  logic [OFS_W-1:0]    off_s;
  logic [3:0]          size_s;
  logic [NB-1:0]       lanes_s, mask_lo_s;
  logic [DATA_W-1:0]   wdata_lo_s, fin_lo_s, fin_hi_s, load_data_s;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] lo,
                                              input logic [DATA_W-1:0] hi,
                                              input logic [OFS_W-1:0]  off);
    return DATA_W'({hi, lo} >> {off, 3'b000});
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw, input logic [2:0] f3);
    logic sgn;
    int   nbits;
    logic [DATA_W-1:0] r;
    case (f3[1:0])
      2'b00:   sgn = raw[7];
      2'b01:   sgn = raw[15];
      2'b10:   sgn = raw[31];
      default: sgn = raw[DATA_W-1];
    endcase
    sgn   = sgn & ~f3[2];
    nbits = 32'd8 << f3[1:0];
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? raw[i] : sgn;
    return r;
  endfunction

  // While idle the live request drives the decode; afterwards the latched copy does.
  assign idle_s      = (state_q == IDLE);
  assign req_ready   = idle_s;
  assign cur_f3_s    = idle_s ? req_funct3 : f3_q;
  assign cur_addr_s  = idle_s ? req_addr   : addr_q;
  assign cur_wdata_s = idle_s ? req_wdata  : wdata_q;
  assign off_s       = cur_addr_s[OFS_W-1:0];
  assign size_s      = 4'd1 << cur_f3_s[1:0];
  assign illegal_s   = ((cur_f3_s[1:0] == 2'b11) && (DATA_W == 32)) || (cur_f3_s == 3'b111);

  always_comb begin
    for (int i = 0; i < NB; i++) lanes_s[i] = (i < int'(size_s));
  end

`ifdef MISALIGN_SPLIT_EN
  logic                crossing_s;
  logic [NB-1:0]       mask_hi_s;
  logic [DATA_W-1:0]   wdata_hi_s, lo_q, lo_d;

  assign crossing_s               = (int'(off_s) + int'(size_s)) > NB;
  assign {mask_hi_s, mask_lo_s}   = {{NB{1'b0}}, lanes_s} << off_s;
  assign {wdata_hi_s, wdata_lo_s} = {{DATA_W{1'b0}}, cur_wdata_s} << {off_s, 3'b000};
  assign err_s                    = illegal_s;
  assign fin_lo_s                 = (state_q == ACC1) ? lo_q : mem_rdata;
  assign fin_hi_s                 = (state_q == ACC1) ? mem_rdata : '0;
`else
  logic                misalign_s;

  assign misalign_s = |({{(4-OFS_W){1'b0}}, off_s} & (size_s - 4'd1));
  assign mask_lo_s  = lanes_s << off_s;
  assign wdata_lo_s = cur_wdata_s << {off_s, 3'b000};
  assign err_s      = illegal_s | misalign_s;
  assign fin_lo_s   = mem_rdata;
  assign fin_hi_s   = '0;
`endif

  assign load_data_s = we_q ? '0 : extend(merge(fin_lo_s, fin_hi_s, off_s), f3_q);

  // Next-state and next-output decode; memory outputs hold unless a transition updates them.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef MISALIGN_SPLIT_EN
    lo_d        = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && err_s) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (req_valid) begin
          state_d     = ACC0;
          mem_read_d  = ~req_we;
          mem_write_d = req_we;
          mem_addr_d  = {cur_addr_s[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          mem_wmask_d = mask_lo_s;
          mem_wdata_d = wdata_lo_s;
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
`ifdef MISALIGN_SPLIT_EN
        if (mem_resp && crossing_s) begin
          state_d     = ACC1;
          lo_d        = mem_rdata;
          mem_addr_d  = mem_addr_q + ADDR_W'(NB);
          mem_wmask_d = mask_hi_s;
          mem_wdata_d = wdata_hi_s;
        end else
`endif
        if (mem_resp) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_s;
        end else begin
          state_d = ACC0;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1: begin
        if (mem_resp) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_s;
        end else begin
          state_d = ACC1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      if (idle_s && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MISALIGN_SPLIT_EN
      lo_q        <= lo_d;
`endif
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Parametrised load/store alignment engine between the MEM stage and the data-memory port. It accepts one load or store per request, generates byte enables and lane-shifted write data for any data-bus width, and sign/zero-extends load data. When enabled, it splits accesses that cross a bus-word boundary into two sequential memory transactions and merges the results. It supersedes the purely combinational byte-mask generation in the data path.

## Interface
- DATA_W, 32: memory bus width in bits. Legal values are 32 and 64. NB = DATA_W/8, OFS_W = log2(NB).
- ADDR_W, 32: address width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code. 000/100 byte, 001/101 half, 010/110 word, 011 double (DATA_W=64 only). Bit 2 = unsigned load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- mem_read  out  1  read strobe, held until mem_resp.
- mem_write  out  1  write strobe, held until mem_resp.
- mem_addr  out  ADDR_W  NB-aligned address.
- mem_wmask  out  NB  byte enables.
- mem_wdata  out  DATA_W  lane-shifted write data.
- mem_rdata  in  DATA_W  read data, valid with mem_resp.
- mem_resp  in  1  transaction complete.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data. Zero for stores.
- rsp_err  out  1  misalign or illegal-width error, valid with rsp_valid.

## Operation
- Size S = 1 << funct3[1:0] bytes. Offset O = req_addr[OFS_W-1:0].
- Illegal width: funct3[1:0]=11 with DATA_W=32, or funct3=111. Response is rsp_valid with rsp_err=1 and no memory access.
- Crossing: O + S > NB.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - IDLE: req_ready=1. On accept, latch all request fields.
  - IDLE to RESP on an illegal width or on a disabled split (see Configuration).
  - IDLE to ACC0 otherwise.
  - ACC0: mem_addr = {addr[ADDR_W-1:OFS_W], 0}. mem_wmask = ((1<<S)-1) << O, truncated to NB bits. mem_wdata = wdata << 8·O.
  - On mem_resp in ACC0: capture mem_rdata into the low buffer. If crossing, go to ACC1. Else go to RESP.
  - ACC1: mem_addr = ACC0 address + NB (wraps modulo 2^ADDR_W). mem_wmask = ((1<<S)-1) >> (NB−O). mem_wdata = wdata >> 8·(NB−O).
  - On mem_resp in ACC1: capture mem_rdata into the high buffer, then go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Load merge: raw = (low >> 8·O) | (high << 8·(NB−O)). Take the low S bytes of raw, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to DATA_W.
- mem_read equals !we and mem_write equals we, asserted only in ACC0 and ACC1.
- mem_resp in IDLE or RESP is ignored.

## Timing
- All outputs are registered except req_ready, which is decoded combinationally from state.
- Reset values:
  - state=IDLE, so req_ready=1.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wmask=0, mem_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency:
  - Request accepted at edge 0. The strobe is high from cycle 1.
  - A mem_resp sampled at edge k causes rsp_valid in cycle k+1.
  - A split access adds the second transaction. Its strobe is high from the cycle after the first mem_resp; the strobe stays high across the ACC0 to ACC1 boundary with the new address.
  - An error response arrives in cycle 1, with no strobe.
- Back-to-back: a new request is accepted in the cycle after rsp_valid. There is no overlap.
- Reset asserted mid-transaction: immediate asynchronous return to IDLE. Strobes drop without waiting for mem_resp. The partial transaction is discarded and no rsp_valid is produced.
- req_valid held during busy states is not accepted. The request fields are not sampled.

## Configuration
- MISALIGN_SPLIT_EN defined: crossing accesses are split as described.
- MISALIGN_SPLIT_EN undefined:
  - Any access with O not a multiple of S goes IDLE to RESP with rsp_err=1 and no memory access. This includes non-crossing misaligned accesses.
  - The ACC1 state and the high buffer are not built.

## Test plan
- DATA_W=32, LB at addr 0x1003. Memory returns 0x80AABBCC -> mem_wmask=1000 and mem_read held until mem_resp. Next cycle: rsp_valid=1, rsp_rdata=0xFFFFFF80, rsp_err=0.
- DATA_W=32, SH at addr 0x2002 with wdata 0x0000BEEF -> mem_addr=0x2000, mem_wmask=1100, mem_wdata=0xBEEF0000, then a single rsp_valid pulse.
- Split enabled, DATA_W=32, LW at 0x0FFE. Words 0x0FFC=0x11223344 and 0x1000=0x55667788 -> two transactions with masks 1100 then 0011. rsp_rdata=0x77881122.
- Split disabled, LW at 0x0FFE -> no strobe, rsp_valid in cycle 1 with rsp_err=1. Repeat with LH at 0x0FFD -> same error.
- DATA_W=64, LWU at 0x3004 with qword 0xF00DCAFE_00000000 -> mem_wmask=0xF0, rsp_rdata=0x00000000_F00DCAFE. With DATA_W=32, funct3=011 -> rsp_err=1.
- rst_n pulled low during ACC1 of a split SW -> strobes drop at once and no rsp_valid is produced. The next request completes normally.
